dmem_bus_ctrl: RTL and testbench
================================

// Module: dmem_bus_ctrl
// PURPOSE
//  Memory-stage data-memory controller; sits directly downstream of the pipelined datapath M stage.
//  Turns the M-stage lw/sw request into a multi-cycle req/gnt/rvalid bus transaction.
//  Raises stall_mem so the hazard unit freezes F/D/E/M and bubbles W until the access retires.
//  Returns load data on rdata, which feeds the datapath ReadData input.
// PARAMETERS
//  ADDR_W       32   address width (byte address)
//  DATA_W       32   data width (word access only)
//  TIMEOUT_CYC  255  watchdog limit in cycles (used only with DMEM_TIMEOUT_EN)
// PORTS
//  clk        in   1       pipeline clock; all state on posedge
//  reset      in   1       asynchronous, active-low reset
//  mem_rd_m   in   1       M-stage instruction is lw
//  mem_wr_m   in   1       M-stage instruction is sw
//  addr_m     in   ADDR_W  ALUResultM (byte address)
//  wdata_m    in   DATA_W  WriteDataM
//  stall_mem  out  1       freeze pipeline; access not yet retired
//  rdata      out  DATA_W  load data to datapath ReadData; held until the next load retires
//  err        out  1       one-cycle pulse in DONE when the access failed
//  bus_req    out  1       bus request; held until bus_gnt
//  bus_we     out  1       1 = write, 0 = read
//  bus_addr   out  ADDR_W  word-aligned address
//  bus_wdata  out  DATA_W  store data
//  bus_gnt    in   1       request accepted this cycle
//  bus_rvalid in   1       read data valid
//  bus_rdata  in   DATA_W  read data
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, rdata=0, err=0.
//  Outputs are 0 while reset is asserted. stall_mem is combinational and is 0 in reset.
//  op = mem_rd_m | mem_wr_m. If both are high, the access is a write.
//  stall_mem = op & (state != DONE). It is combinational, so it rises in the same cycle op appears.
//  State machine:
//   IDLE : op & addr_m[1:0]==0 -> REQ; latch addr/wdata/we into bus_* regs.
//          op & addr_m[1:0]!=0 -> DONE with err flag set; no bus access.
//   REQ  : bus_req=1; addr/we/wdata stable. On gnt & write -> DONE. On gnt & read -> WAIT.
//          bus_rvalid is ignored in REQ.
//   WAIT : bus_req=0. On bus_rvalid: rdata<=bus_rdata -> DONE.
//   DONE : stall_mem=0 for exactly 1 cycle; err pulses if flagged; -> IDLE.
//          The M stage advances at the end of this cycle. No new request is issued in DONE,
//          so a back-to-back memory op starts from IDLE on the next cycle.
//  Minimum latency:
//   Load with gnt in the first REQ cycle and rvalid 1 cycle later = 3 stall cycles (IDLE, REQ, WAIT).
//   Store = 2 stall cycles.
//  rvalid while in IDLE or DONE: ignored, no state change.
//  op dropping mid-transaction (flush) is not allowed; the controller completes the access regardless.
//  Reset mid-transaction drops bus_req at once; the bus side must tolerate an abandoned request.
// CONFIGURATION
//  DMEM_TIMEOUT_EN defined:
//   A counter runs in REQ and WAIT. When it reaches TIMEOUT_CYC -> DONE with err=1.
//   On a read timeout, rdata<=0. The counter clears on IDLE.
//  DMEM_TIMEOUT_EN undefined: no counter; the controller waits indefinitely; err only on misalign.
// STRUCTURE
//  dmem_bus_pkg: typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} dmem_state_t;
//                localparam for the misalign mask.
//  Sub-module dmem_timeout_cnt (enable, clear, hit output); instantiated only under DMEM_TIMEOUT_EN.
// TESTING
//  lw addr=0x64, gnt at once, rvalid+1 with 0x19:
//   -> stall_mem high 3 cycles, rdata=0x19 in DONE, err=0.
//  sw addr=0x64 wdata=0x19, gnt delayed 4 cycles:
//   -> bus_req held 5 cycles with addr/wdata stable, stall 6 cycles, no rdata change.
//  Back-to-back lw 0x10 then lw 0x14:
//   -> two distinct bus_req pulses with an IDLE gap, and no re-issue of 0x10.
//  lw addr=0x66 (misaligned):
//   -> bus_req never asserted, err pulses 1 cycle, stall 1 cycle.
//  Reset low during WAIT:
//   -> bus_req=0 and state IDLE immediately; a later rvalid is ignored.
//  DMEM_TIMEOUT_EN, TIMEOUT_CYC=8, gnt never:
//   -> err after 8 REQ cycles, stall released in DONE.

Source files
------------

// File: rtl/dmem_bus_pkg.sv
// Shared types for the M-stage data-memory bus controller.
package dmem_bus_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} dmem_state_t;

    localparam logic [1:0] MISALIGN_MASK = 2'b11;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Watchdog cycle counter for outstanding bus accesses (used with DMEM_TIMEOUT_EN).
module dmem_timeout_cnt #(
    parameter int unsigned LIMIT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_hit
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != CW'(LIMIT))) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Fires during the LIMIT-th enabled cycle so the access ends after exactly LIMIT cycles.
    assign o_hit = i_en && (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/dmem_bus_ctrl.sv
// M-stage lw/sw to req/gnt/rvalid bus controller with pipeline stall.
// Optional watchdog enabled by defining DMEM_TIMEOUT_EN.
module dmem_bus_ctrl
    import dmem_bus_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_rd_m,
    input  logic              mem_wr_m,
    input  logic [ADDR_W-1:0] addr_m,
    input  logic [DATA_W-1:0] wdata_m,
    output logic              stall_mem,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata
);

    dmem_state_t       r_state;
    dmem_state_t       w_next;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;
    logic              r_bus_we;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic w_op;
    logic w_misaligned;
    logic w_to_hit;

    assign w_op         = mem_rd_m | mem_wr_m;
    assign w_misaligned = |(addr_m[1:0] & MISALIGN_MASK);

`ifdef DMEM_TIMEOUT_EN
    dmem_timeout_cnt #(
        .LIMIT(TIMEOUT_CYC)
    ) u_timeout (
        .i_clk  (clk),
        .i_rst_n(reset),
        .i_en   ((r_state == REQ) || (r_state == WAIT)),
        .i_clr  (r_state == IDLE),
        .o_hit  (w_to_hit)
    );
`else
    // Watchdog compiled out; the parameter stays so overrides work in either build.
    assign w_to_hit = 1'b0 && (TIMEOUT_CYC != 0);
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_op) w_next = w_misaligned ? DONE : REQ;
            REQ: begin
                if (bus_gnt)       w_next = bus_we ? DONE : WAIT;
                else if (w_to_hit) w_next = DONE;
            end
            WAIT: if (bus_rvalid || w_to_hit) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_we    <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_op) begin
                        r_err <= w_misaligned;
                        if (!w_misaligned) begin
                            r_bus_addr  <= addr_m & ~ADDR_W'(MISALIGN_MASK);
                            r_bus_wdata <= wdata_m;
                            r_bus_we    <= mem_wr_m;
                        end
                    end
                end
                REQ: if (!bus_gnt && w_to_hit) r_err <= 1'b1;
                WAIT: begin
                    if (bus_rvalid) begin
                        r_rdata <= bus_rdata;
                    end else if (w_to_hit) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Gated by reset so the hazard unit sees no stall while the controller is held in reset.
    assign stall_mem = reset & w_op & (r_state != DONE);
    assign err       = (r_state == DONE) & r_err;
    assign bus_req   = (r_state == REQ);
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign rdata     = r_rdata;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Self-checking bench for dmem_bus_ctrl: directed table, reset corners, random transactions.
module tb_dmem_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_rd_m, mem_wr_m;
    logic [31:0] addr_m, wdata_m;
    logic        stall_mem;
    logic [31:0] rdata;
    logic        err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] m_rdata = '0;

    always #5 clk = ~clk;

    dmem_bus_ctrl #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_rd_m  (mem_rd_m),
        .mem_wr_m  (mem_wr_m),
        .addr_m    (addr_m),
        .wdata_m   (wdata_m),
        .stall_mem (stall_mem),
        .rdata     (rdata),
        .err       (err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_gnt   (bus_gnt),
        .bus_rvalid(bus_rvalid),
        .bus_rdata (bus_rdata)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gdly;      // REQ cycles without gnt before the granting cycle
        int          vdly;      // WAIT cycles without rvalid before the valid cycle
        logic [31:0] rdat;
        int          exp_stall;
        int          exp_req;
        logic        exp_err;
        logic        exp_we;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input int g, input int v,
                                input logic [31:0] rdat, input int es, input int er,
                                input logic ee, input logic ew, input logic [31:0] erd);
        vec_t t;
        t.rd = rd; t.wr = wr; t.addr = addr; t.wdata = wdata; t.gdly = g; t.vdly = v;
        t.rdat = rdat; t.exp_stall = es; t.exp_req = er; t.exp_err = ee; t.exp_we = ew;
        t.exp_rdata = erd;
        return t;
    endfunction

    // Transaction-level reference: latency and results from the access rules alone.
    function automatic vec_t model(input vec_t t, input logic [31:0] prev_rdata);
        vec_t r = t;
        logic mis = (t.addr[1:0] != 2'b00);
        r.exp_we    = t.wr;
        r.exp_err   = mis;
        r.exp_req   = mis ? 0 : t.gdly + 1;
        r.exp_stall = mis ? 1 : (t.wr ? 2 + t.gdly : 3 + t.gdly + t.vdly);
        r.exp_rdata = (!mis && !t.wr) ? t.rdat : prev_rdata;
        return r;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        int   stall_n = 0, req_n = 0, wcnt = 0;
        bit   done = 0, fields_ok = 1, wait_rd = 0;
        mem_rd_m = v.rd; mem_wr_m = v.wr; addr_m = v.addr; wdata_m = v.wdata;
        bus_gnt = 0; bus_rvalid = 0; bus_rdata = '0;
        #1;
        chk({tag, ".idle_gap"}, {31'd0, bus_req}, 32'd0);
        chk({tag, ".rdata_held"}, rdata, m_rdata);
        for (int c = 0; c < 300 && !done; c++) begin
            if (c != 0) #1;
            if (bus_req) begin
                req_n++;
                if (bus_addr !== (v.addr & ~32'h3) || bus_we !== v.exp_we ||
                    (v.exp_we && bus_wdata !== v.wdata)) fields_ok = 0;
            end
            if (stall_mem) begin
                stall_n++;
                if (err) fields_ok = 0;
            end else begin
                chk({tag, ".stall_cycles"}, stall_n, v.exp_stall);
                chk({tag, ".req_cycles"}, req_n, v.exp_req);
                chk({tag, ".err"}, {31'd0, err}, {31'd0, v.exp_err});
                chk({tag, ".rdata"}, rdata, v.exp_rdata);
                done = 1;
            end
            bus_gnt = bus_req && (req_n - 1 == v.gdly);
            if (wait_rd) begin
                bus_rvalid = (wcnt == v.vdly);
                bus_rdata  = v.rdat;
                wcnt++;
            end else begin
                bus_rvalid = $urandom_range(1, 0);
                bus_rdata  = $urandom;
            end
            if (bus_gnt && !v.exp_we) wait_rd = 1;
            @(posedge clk);
            #1;
        end
        chk({tag, ".completed"}, {31'd0, done}, 32'd1);
        chk({tag, ".bus_fields"}, {31'd0, fields_ok}, 32'd1);
        m_rdata = v.exp_rdata;
        mem_rd_m = 0; mem_wr_m = 0; bus_gnt = 0; bus_rvalid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        vec_t r;

        reset = 0; mem_rd_m = 1; mem_wr_m = 0; addr_m = 32'h64; wdata_m = 32'h19;
        bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'hFFFF_FFFF;
        #2;
        chk("rst.stall", {31'd0, stall_mem}, 32'd0);
        chk("rst.bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst.err", {31'd0, err}, 32'd0);
        chk("rst.rdata", rdata, 32'd0);
        chk("rst.bus_addr", bus_addr, 32'd0);
        chk("rst.bus_wdata", bus_wdata, 32'd0);
        chk("rst.bus_we", {31'd0, bus_we}, 32'd0);
        #10;
        mem_rd_m = 0; bus_rvalid = 0;
        reset = 1;
        @(posedge clk); #1;

        //         rd wr addr           wdata      g v rdat          stall req err we rdata
        tbl.push_back(mk(1, 0, 32'h64,       32'h0,     0, 0, 32'h19,       3, 1, 0, 0, 32'h19));
        tbl.push_back(mk(0, 1, 32'h64,       32'h19,    4, 0, 32'h0,        6, 5, 0, 1, 32'h19));
        tbl.push_back(mk(1, 0, 32'h10,       32'h0,     0, 1, 32'hA,        4, 1, 0, 0, 32'hA));
        tbl.push_back(mk(1, 0, 32'h14,       32'h0,     2, 0, 32'hB,        5, 3, 0, 0, 32'hB));
        tbl.push_back(mk(1, 0, 32'h66,       32'h0,     0, 0, 32'h77,       1, 0, 1, 0, 32'hB));
        tbl.push_back(mk(1, 1, 32'h20,       32'hCAFE,  0, 0, 32'h55,       2, 1, 0, 1, 32'hB));
        tbl.push_back(mk(0, 1, 32'h7,        32'h1234,  0, 0, 32'h0,        1, 0, 1, 1, 32'hB));
        tbl.push_back(mk(1, 0, 32'hFFFFFFFC, 32'h0,     1, 2, 32'hFFFFFFFF, 6, 2, 0, 0, 32'hFFFFFFFF));
`ifdef DMEM_TIMEOUT_EN
        tbl.push_back(mk(0, 1, 32'h20,       32'h5A5A,  1000, 0, 32'h0,     9, 8, 1, 1, 32'hFFFFFFFF));
        tbl.push_back(mk(1, 0, 32'h24,       32'h0,     0, 1000, 32'h99,    9, 1, 1, 0, 32'h0));
`endif
        foreach (tbl[i]) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Reset asserted while a request is pending drops bus_req immediately.
        mem_rd_m = 1; addr_m = 32'h40;
        @(posedge clk); #1;
        chk("rstreq.req_before", {31'd0, bus_req}, 32'd1);
        reset = 0; #1;
        chk("rstreq.req_after", {31'd0, bus_req}, 32'd0);
        mem_rd_m = 0; #2; reset = 1;
        @(posedge clk); #1;

        // Reset during WAIT, then a stray rvalid must be ignored.
        mem_rd_m = 1; addr_m = 32'h44;
        @(posedge clk); #1;
        bus_gnt = 1;
        @(posedge clk); #1;
        bus_gnt = 0;
        chk("rstwait.stall_before", {31'd0, stall_mem}, 32'd1);
        reset = 0; #1;
        chk("rstwait.stall", {31'd0, stall_mem}, 32'd0);
        chk("rstwait.bus_req", {31'd0, bus_req}, 32'd0);
        chk("rstwait.rdata", rdata, 32'd0);
        m_rdata = '0;
        mem_rd_m = 0; #2; reset = 1;
        @(posedge clk); #1;
        bus_rvalid = 1; bus_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus_rvalid = 0;
        chk("rstwait.stray_rvalid", rdata, 32'd0);
        chk("rstwait.no_err", {31'd0, err}, 32'd0);
        run_txn(model(mk(1, 0, 32'h80, 32'h0, 0, 0, 32'h55, 0, 0, 0, 0, 0), m_rdata), "post_rst");

        for (int i = 0; i < 150; i++) begin
            r.rd    = $urandom_range(1, 0);
            r.wr    = $urandom_range(1, 0);
            if (!r.rd && !r.wr) r.rd = 1;
            r.addr  = $urandom;
            if ($urandom_range(3, 0) != 0) r.addr[1:0] = 2'b00;
            r.wdata = $urandom;
            r.rdat  = $urandom;
            r.gdly  = $urandom_range(3, 0);
            r.vdly  = $urandom_range(3, 0);
            run_txn(model(r, m_rdata), $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
